// File: rtl/alu_seq_ctrl_if.sv
// Request/response bundle between the multi-cycle control FSM and alu_seq_ctrl.
// The master side issues requests and the slave side (the ALU) answers them.
interface alu_seq_ctrl_if #(
  parameter int WIDTH  = 32,
  parameter int FUNC_W = 6
);
  // Handshake: a request is taken on a rising edge where start && ready.
  // ALUOp/func/a/b matter only on that edge. done pulses for one cycle with
  // operation/result/result_hi/zero/illegal valid. The result fields then hold.
  logic              start;
  logic [1:0]        ALUOp;
  logic [FUNC_W-1:0] func;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              ready;
  logic              done;
  logic [2:0]        operation;
  logic [WIDTH-1:0]  result;
  logic [WIDTH-1:0]  result_hi;
  logic              zero;
  logic              illegal;

  modport master (
    output start, ALUOp, func, a, b,
    input  ready, done, operation, result, result_hi, zero, illegal
  );

  modport slave (
    input  start, ALUOp, func, a, b,
    output ready, done, operation, result, result_hi, zero, illegal
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle ALU controller: decodes ALUOp/func, executes, and returns registered results.
// Define ALU_MULT_EN to include the iterative unsigned shift-add multiplier (MULT).
module alu_seq_ctrl #(
  parameter int WIDTH  = 32,
  parameter int FUNC_W = 6
) (
  input  logic          clk,
  input  logic          rst,
  alu_seq_ctrl_if.slave bus,
  output logic [1:0]    state_o
);

  localparam logic [2:0] OP_NOTHING = 3'd0;
  localparam logic [2:0] OP_ADD     = 3'd1;
  localparam logic [2:0] OP_SUB     = 3'd2;
  localparam logic [2:0] OP_AND     = 3'd3;
  localparam logic [2:0] OP_OR      = 3'd4;
  localparam logic [2:0] OP_SLT     = 3'd5;
  localparam logic [2:0] OP_MUL     = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MUL_RUN = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t           state_q;
  logic             ready_q;
  logic             done_q;
  logic             zero_q;
  logic             illegal_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] result_hi_q;

  logic [2:0]       op_dec;
  logic [WIDTH-1:0] alu_res;

  always_comb begin
    op_dec = OP_NOTHING;
    case (bus.ALUOp)
      2'b00: op_dec = OP_ADD;
      2'b01: op_dec = OP_SUB;
      2'b10: op_dec = OP_SLT;
      default: begin
        case (bus.func)
          FUNC_W'(1):  op_dec = OP_ADD;
          FUNC_W'(2):  op_dec = OP_SUB;
          FUNC_W'(4):  op_dec = OP_AND;
          FUNC_W'(8):  op_dec = OP_OR;
          FUNC_W'(16): op_dec = OP_SLT;
`ifdef ALU_MULT_EN
          FUNC_W'(32): op_dec = OP_MUL;
`endif
          default:     op_dec = OP_NOTHING;
        endcase
      end
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (op_dec)
      OP_ADD:  alu_res = bus.a + bus.b;
      OP_SUB:  alu_res = bus.a - bus.b;
      OP_AND:  alu_res = bus.a & bus.b;
      OP_OR:   alu_res = bus.a | bus.b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_MULT_EN
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   mcand_q;
  // Upper half accumulates partial sums; lower half starts as the multiplier
  // and is shifted out LSB first while product bits shift in behind it.
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH:0]     partial;
  logic [2*WIDTH-1:0] acc_step;

  always_comb begin
    partial  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    acc_step = {partial, acc_q[WIDTH-1:1]};
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
      op_q        <= OP_NOTHING;
      result_q    <= '0;
      result_hi_q <= '0;
`ifdef ALU_MULT_EN
      cnt_q       <= '0;
      mcand_q     <= '0;
      acc_q       <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            op_q    <= op_dec;
            ready_q <= 1'b0;
`ifdef ALU_MULT_EN
            if (op_dec == OP_MUL) begin
              mcand_q <= bus.a;
              acc_q   <= {{WIDTH{1'b0}}, bus.b};
              cnt_q   <= CNT_W'(WIDTH);
              state_q <= S_MUL_RUN;
            end else begin
`else
            begin
`endif
              result_q    <= alu_res;
              result_hi_q <= '0;
              zero_q      <= (alu_res == '0);
              illegal_q   <= (op_dec == OP_NOTHING);
              done_q      <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end
`ifdef ALU_MULT_EN
        S_MUL_RUN: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            result_q    <= acc_step[WIDTH-1:0];
            result_hi_q <= acc_step[2*WIDTH-1:WIDTH];
            zero_q      <= (acc_step == '0);
            illegal_q   <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          done_q    <= 1'b0;
          illegal_q <= 1'b0;
          ready_q   <= 1'b1;
          state_q   <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ready     = ready_q;
  assign bus.done      = done_q;
  assign bus.operation = op_q;
  assign bus.result    = result_q;
  assign bus.result_hi = result_hi_q;
  assign bus.zero      = zero_q;
  assign bus.illegal   = illegal_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: directed cases plus random requests checked against an arithmetic model.
// Follows the ALU_MULT_EN define of the build to decide what MULT should produce.
module tb_alu_seq_ctrl;
  localparam int W  = 32;
  localparam int FW = 6;
`ifdef ALU_MULT_EN
  localparam bit MULT_EN = 1'b1;
`else
  localparam bit MULT_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_seq_ctrl_if #(.WIDTH(W), .FUNC_W(FW)) bus ();
  logic [1:0] state_dbg;

  alu_seq_ctrl #(.WIDTH(W), .FUNC_W(FW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state_dbg)
  );

  // scoreboard
  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model straight from the operation table.
  function automatic void model(input logic [1:0] op, input logic [FW-1:0] fn,
                                input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [2:0] eop, output logic [W-1:0] r,
                                output logic [W-1:0] rh, output int lat);
    logic [2*W-1:0] p;
    eop = 3'd0;
    r   = '0;
    rh  = '0;
    lat = 1;
    if (op == 2'b00) eop = 3'd1;
    else if (op == 2'b01) eop = 3'd2;
    else if (op == 2'b10) eop = 3'd5;
    else begin
      case (fn)
        6'b000001: eop = 3'd1;
        6'b000010: eop = 3'd2;
        6'b000100: eop = 3'd3;
        6'b001000: eop = 3'd4;
        6'b010000: eop = 3'd5;
        6'b100000: eop = MULT_EN ? 3'd6 : 3'd0;
        default:   eop = 3'd0;
      endcase
    end
    case (eop)
      3'd1: r = a + b;
      3'd2: r = a - b;
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: begin
        p   = {32'b0, a} * {32'b0, b};
        r   = p[W-1:0];
        rh  = p[2*W-1:W];
        lat = W + 1;
      end
      default: r = '0;
    endcase
  endfunction

  // driver tasks
  task automatic scramble_inputs();
    bus.ALUOp = 2'($urandom_range(0, 3));
    bus.func  = FW'($urandom_range(0, 63));
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  task automatic wait_ready();
    int guard = 0;
    @(negedge clk);
    while (!bus.ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check_eq("wait_ready", 64'(bus.ready), 64'd1);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [FW-1:0] fn,
                        input logic [W-1:0] a, input logic [W-1:0] b, input bit noise);
    logic [2:0]   eop;
    logic [W-1:0] r, rh, er;
    int           lat, lat_obs;
    bit           busy_bad;
    model(op, fn, a, b, eop, r, rh, lat);
    exp_q.push_back(r);
    wait_ready();
    bus.start = 1'b1;
    bus.ALUOp = op;
    bus.func  = fn;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    scramble_inputs();
    @(negedge clk);
    lat_obs  = 1;
    busy_bad = 1'b0;
    while (!bus.done && lat_obs < W + 5) begin
      if (bus.ready) busy_bad = 1'b1;
      if (noise) begin
        bus.start = 1'($urandom_range(0, 1));
        scramble_inputs();
      end
      @(negedge clk);
      lat_obs++;
    end
    bus.start = 1'b0;
    er = exp_q.pop_front();
    check_eq("latency",    64'(lat_obs), 64'(lat));
    check_eq("busy_ready", 64'(busy_bad), 64'd0);
    check_eq("done_ready", 64'(bus.ready), 64'd0);
    check_eq("operation",  64'(bus.operation), 64'(eop));
    check_eq("result",     64'(bus.result), 64'(er));
    check_eq("result_hi",  64'(bus.result_hi), 64'(rh));
    check_eq("zero",       64'(bus.zero), 64'((r == '0) && (rh == '0)));
    check_eq("illegal",    64'(bus.illegal), 64'(eop == 3'd0));
    @(negedge clk);
    check_eq("post_ready",   64'(bus.ready), 64'd1);
    check_eq("post_done",    64'(bus.done), 64'd0);
    check_eq("post_illegal", 64'(bus.illegal), 64'd0);
    check_eq("post_result",  64'(bus.result), 64'(er));
    check_eq("post_op",      64'(bus.operation), 64'(eop));
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_ready"},   64'(bus.ready), 64'd1);
    check_eq({tag, "_done"},    64'(bus.done), 64'd0);
    check_eq({tag, "_op"},      64'(bus.operation), 64'd0);
    check_eq({tag, "_result"},  64'(bus.result), 64'd0);
    check_eq({tag, "_hi"},      64'(bus.result_hi), 64'd0);
    check_eq({tag, "_zero"},    64'(bus.zero), 64'd0);
    check_eq({tag, "_illegal"}, 64'(bus.illegal), 64'd0);
    check_eq({tag, "_state"},   64'(state_dbg), 64'd0);
  endtask

  // Accept a request, then raise rst during the k-th cycle after acceptance.
  task automatic reset_during(input logic [1:0] op, input logic [FW-1:0] fn,
                              input logic [W-1:0] a, input logic [W-1:0] b, input int k);
    logic [2:0]   eop;
    logic [W-1:0] r, rh;
    int           lat;
    bit           done_seen;
    model(op, fn, a, b, eop, r, rh, lat);
    wait_ready();
    bus.start = 1'b1;
    bus.ALUOp = op;
    bus.func  = fn;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    done_seen = 1'b0;
    for (int c = 1; c <= k; c++) begin
      @(negedge clk);
      if (bus.done) done_seen = 1'b1;
    end
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_done_seen", 64'(done_seen), 64'(k >= lat));
    check_reset_values("abort");
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]    op;
    logic [FW-1:0] fn;
    logic [W-1:0]  a, b;
    int            sel;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.ALUOp = 2'b00;
    bus.func  = '0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    run_op(2'b11, 6'b000010, 32'd5, 32'd7, 1'b0);
    run_op(2'b10, 6'b111111, 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op(2'b01, 6'b000000, 32'h1234, 32'h1234, 1'b0);
    run_op(2'b11, 6'b000011, 32'hDEAD_BEEF, 32'h1, 1'b0);
    run_op(2'b11, 6'b000000, 32'h55, 32'hAA, 1'b0);
    run_op(2'b11, 6'b000100, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0);
    run_op(2'b11, 6'b001000, 32'hF000_0000, 32'h0000_000F, 1'b0);
    run_op(2'b11, 6'b010000, 32'd3, 32'hFFFF_FFFE, 1'b0);
    run_op(2'b00, 6'b000100, 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op(2'b11, 6'b100000, 32'hFFFF_FFFF, 32'd2, 1'b1);
    run_op(2'b11, 6'b100000, 32'd3, 32'd4, 1'b0);
    run_op(2'b11, 6'b100000, 32'd0, 32'hFFFF_FFFF, 1'b0);

    reset_during(2'b11, 6'b100000, 32'h1234_5678, 32'h9ABC_DEF0, 10);
    run_op(2'b00, 6'b000000, 32'd3, 32'd4, 1'b0);
    reset_during(2'b00, 6'b000000, 32'd9, 32'd9, 1);

    // rst wins over a simultaneous start
    @(negedge clk);
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.ALUOp = 2'b00;
    bus.a     = 32'd1;
    bus.b     = 32'd1;
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;
    check_reset_values("rst_start");
    @(negedge clk);
    check_eq("rst_start_no_done", 64'(bus.done), 64'd0);

    for (int i = 0; i < 30; i++) begin
      op  = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 7);
      if (sel < 6) fn = FW'(1) << sel;
      else         fn = FW'($urandom_range(0, 63));
      case ($urandom_range(0, 5))
        0:       begin a = '0; b = $urandom; end
        1:       begin a = $urandom; b = a; end
        2:       begin a = 32'hFFFF_FFFF; b = $urandom; end
        default: begin a = $urandom; b = $urandom; end
      endcase
      run_op(op, fn, a, b, 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 3; i++) begin
      a = $urandom;
      b = $urandom;
      run_op(2'b11, 6'b100000, a, b, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Multi-cycle successor to the single-cycle ALU controller: decodes ALUOp/func exactly as the datapath controller does, latches operands, executes the selected operation and returns a registered result with a ready/start/done handshake. Adds an iterative unsigned multiply (MULT) that occupies the block for WIDTH cycles. Sits between the multi-cycle control FSM and the register file write-back path.

## Interface
- WIDTH, 32, operand/result width (≥4).
- FUNC_W, 6, width of func field.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only when ready=1.
- ALUOp  in  2  00=ADD, 01=SUB, 10=SLT, 11=decode func.
- func  in  FUNC_W  one-hot: 000001 ADD, 000010 SUB, 000100 AND, 001000 OR, 010000 SLT, 100000 MULT.
- a, b  in  WIDTH  operands.
- ready  out  1  block idle, can accept start.
- done  out  1  one-cycle pulse, result outputs valid.
- operation  out  3  latched decode: 000 NOTHING, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 SLT, 110 MUL.
- result  out  WIDTH  result (low half for MUL).
- result_hi  out  WIDTH  high half for MUL, else 0.
- zero  out  1  result==0 (and result_hi==0 for MUL); valid with done.
- illegal  out  1  asserted with done when operation==NOTHING.

## Operation
- States: IDLE, MUL_RUN, DONE. ready = (state==IDLE).
- IDLE: start=1 → latch a, b, decoded operation. Non-MUL → compute, register result, go DONE. MUL → clear accumulator, load counter=WIDTH, go MUL_RUN.
- MUL_RUN: one shift-add step per cycle (unsigned, multiplier LSB first, 2·WIDTH-bit product); counter decrements; at last step go DONE.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- Decode: ALUOp 00/01/10 ignore func. ALUOp 11 with func not one of the listed codes (incl. zero or multi-hot) → NOTHING.
- Arithmetic: ADD/SUB modulo 2^WIDTH, no overflow flag. SLT signed two's-complement, result 1 or 0. AND/OR bitwise. NOTHING → result=0, result_hi=0, zero=1, illegal=1.
- result, result_hi, zero, operation hold their values after done until the next accepted request completes; illegal clears after DONE.
- start while ready=0 ignored (not queued). Operand/func changes after acceptance have no effect.

## Timing
- Reset: state=IDLE, ready=1, done=0, operation=000, result=0, result_hi=0, zero=0, illegal=0, counter=0.
- Accept in cycle N. Non-MUL: done at N+1. MUL: MUL_RUN N+1..N+WIDTH, done at N+WIDTH+1.
- ready=0 from N+1 through done cycle; ready=1 the cycle after done; earliest next accept one cycle after done (throughput 1 op/2 cycles for non-MUL).
- rst during MUL_RUN or DONE: aborts, no done pulse, reset values next cycle; rst overrides simultaneous start.
- No combinational path from inputs to outputs.

## Configuration
- ALU_MULT_EN defined: MULT decoded to MUL, iterative multiplier and counter present.
- Undefined: multiplier logic removed; func 100000 decodes to NOTHING, completes at N+1 with result=0, result_hi=0, illegal=1; result_hi tied to 0.

## Test plan
- Reset: assert rst 2 cycles → ready=1, done=0, all outputs at reset values.
- ALUOp=11, func=000010, a=5, b=7 → done at N+1, operation=010, result=0xFFFFFFFE, zero=0; ALUOp=10, a=0xFFFFFFFF, b=1 → result=1.
- ALUOp=01, a=b=0x1234 → result=0, zero=1; ALUOp=11, func=000011 → operation=000, result=0, illegal=1.
- ALU_MULT_EN defined, MULT a=0xFFFFFFFF, b=2 → ready=0 N+1..N+33, done at N+33, result_hi=0x00000001, result=0xFFFFFFFE; start pulses during busy ignored.
- MULT in progress, assert rst at N+10 → no done pulse, ready=1 at N+11, result=0; then ADD 3+4 → result=7 at done.
- ALU_MULT_EN undefined, MULT a=3, b=4 → done at N+1, illegal=1, result=0, result_hi=0.
